pipe_ctrl_gen: RTL and testbench
================================

// Module: pipe_ctrl_gen
// PURPOSE
//  Parametrised pipeline hazard/exception controller for the multi-cycle CPU core.
//  Merges per-stage stall requests into a stall vector and redirects the PC on exceptions/ERET.
//  Holds flush for a programmable number of cycles via an IDLE/FLUSH state machine.
//  Runs a stall watchdog that flags runaway stalls. Sits beside the pipeline; drives PC, IF..WB regs.
// PARAMETERS
//  NSTAGE        6            number of pipeline stages / stall bits (bit0 = PC)
//  FLUSH_CYCLES  1            cycles flush_o stays high per redirect (1..15)
//  INT_VEC       32'h00000020 redirect target for interrupt (excepttype 0x1)
//  GEN_VEC       32'h00000040 redirect target for syscall/RI/ov/trap (0x8,0xa,0xc,0xd)
//  STALL_TIMEOUT 1024         consecutive stall cycles before stall_timeout_o sets (>=2)
// PORTS
//  clk              in   1       clock, rising edge
//  rst              in   1       synchronous reset, active-high
//  stallreq_i       in   NSTAGE  stall request, bit k from stage k
//  excepttype_i     in   32      exception code from MEM stage, 0 = none
//  cp0_epc_i        in   32      EPC from CP0, used for ERET (0xe)
//  timeout_clr_i    in   1       clears sticky stall_timeout_o
//  stall_o          out  NSTAGE  stall vector, bit j freezes stage j
//  flush_o          out  1       flush all pipeline registers
//  pc_load_o        out  1       one-cycle pulse: PC takes new_pc_o
//  new_pc_o         out  32      redirect target
//  busy_o           out  1       FSM in FLUSH state
//  stall_timeout_o  out  1       sticky watchdog flag
// BEHAVIOUR
//  Reset (sync, rst=1): state=IDLE, flush_cnt=0, new_pc_q=0, stall_cnt=0, stall_timeout_o=0;
//   while rst=1 all outputs forced 0 (stall_o=0, flush_o=0, pc_load_o=0, new_pc_o=0, busy_o=0).
//  Exception decode (comb): valid codes 0x1->INT_VEC, 0x8/0xa/0xc/0xd->GEN_VEC, 0xe->cp0_epc_i.
//   Any other nonzero code is not a redirect: treated as 0 (no flush, no stall effect).
//  Stall merge (comb, IDLE, no valid exception): hi = highest k with stallreq_i[k]=1;
//   stall_o[j]=1 for all j<=hi, else 0. No request -> stall_o=0. E.g. NSTAGE=6,
//   req bit3 -> 6'b001111; req bit2 -> 6'b000111; bits 2 and 3 -> 6'b001111.
//  FSM IDLE: valid exception in cycle t -> same cycle flush_o=1, pc_load_o=1, stall_o=0,
//   new_pc_o=decoded target (comb); at edge new_pc_q<=target. If FLUSH_CYCLES=1 stay IDLE,
//   else state<=FLUSH, flush_cnt<=FLUSH_CYCLES-1.
//  FSM FLUSH: flush_o=1, busy_o=1, stall_o=0, pc_load_o=0, new_pc_o=new_pc_q; flush_cnt
//   decrements each cycle; at flush_cnt==1 next state IDLE. excepttype_i and stallreq_i
//   ignored in FLUSH (pipeline contents being discarded).
//  IDLE without exception: flush_o=0, pc_load_o=0, new_pc_o=0.
//  Exception beats stall: a valid exception with stallreq_i!=0 same cycle -> stall_o=0, redirect.
//  Watchdog: stall_cnt increments each cycle stall_o!=0, clears on any cycle stall_o==0;
//   saturates at STALL_TIMEOUT. When stall_cnt reaches STALL_TIMEOUT-1 and stall_o!=0,
//   stall_timeout_o sets next edge; stays 1 until timeout_clr_i or rst. timeout_clr_i and a
//   new set in same cycle -> set wins. Watchdog has no effect on stall_o.
//  Reset mid-FLUSH: next edge returns to IDLE, flush drops, no residual pc_load_o.
//  Latency: stall/flush/redirect 0 cycles (comb) from request; state visible next cycle.
// TESTING
//  1 NSTAGE=6, stallreq_i=6'b001000 for 3 cycles -> stall_o=6'b001111 each cycle, then 0.
//  2 stallreq_i=6'b000100 and excepttype_i=0x8 same cycle -> stall_o=0, flush_o=1,
//    pc_load_o=1, new_pc_o=0x40.
//  3 FLUSH_CYCLES=3, excepttype_i=0xe, cp0_epc_i=0x1234 -> flush_o high 3 cycles,
//    pc_load_o only first, new_pc_o=0x1234 all 3, busy_o cycles 2-3; second 0x1 in cycle 2 ignored.
//  4 excepttype_i=0x5 (unmapped) with stallreq_i=6'b000010 -> flush_o=0, stall_o=6'b000011.
//  5 STALL_TIMEOUT=4, stall held 4 cycles -> stall_timeout_o=1 after 4th edge; break
//    stall for 1 cycle keeps flag; timeout_clr_i pulse -> 0.
//  6 rst asserted in cycle 2 of 3-cycle flush -> next cycle flush_o=0, busy_o=0, all outputs 0.

Source files
------------

// File: rtl/pipe_ctrl_gen_if.sv
// Handshake bundle between the pipeline hazard/exception controller and the core.
// The master side is the pipeline (stall requests, exception codes, EPC); the
// slave side is the controller that answers with stall, flush and PC redirect.
interface pipe_ctrl_gen_if #(
  parameter int NSTAGE = 6
);
  logic [NSTAGE-1:0] stallreq_i;
  logic [31:0]       excepttype_i;
  logic [31:0]       cp0_epc_i;
  logic              timeout_clr_i;
  logic [NSTAGE-1:0] stall_o;
  logic              flush_o;
  logic              pc_load_o;
  logic [31:0]       new_pc_o;
  logic              busy_o;
  logic              stall_timeout_o;

  modport master (
    output stallreq_i, excepttype_i, cp0_epc_i, timeout_clr_i,
    input  stall_o, flush_o, pc_load_o, new_pc_o, busy_o, stall_timeout_o
  );

  modport slave (
    input  stallreq_i, excepttype_i, cp0_epc_i, timeout_clr_i,
    output stall_o, flush_o, pc_load_o, new_pc_o, busy_o, stall_timeout_o
  );
endinterface

// File: rtl/pipe_ctrl_gen.sv
// Pipeline hazard/exception controller.
// Merges per-stage stall requests into a thermometer stall vector, redirects the
// PC on exceptions/ERET, holds flush for FLUSH_CYCLES cycles through an IDLE/FLUSH
// state machine and runs a sticky watchdog on back-to-back stall cycles.
// Stall/flush/redirect are combinational so the pipeline reacts in the same cycle.
module pipe_ctrl_gen #(
  parameter int          NSTAGE        = 6,
  parameter int          FLUSH_CYCLES  = 1,
  parameter logic [31:0] INT_VEC       = 32'h0000_0020,
  parameter logic [31:0] GEN_VEC       = 32'h0000_0040,
  parameter int          STALL_TIMEOUT = 1024
) (
  input logic           clk,
  input logic           rst,
  pipe_ctrl_gen_if.slave bus
);

  localparam int CW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [3:0]    FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX      = CW'(STALL_TIMEOUT);
  localparam logic [CW-1:0] CNT_ARM      = CW'(STALL_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t            state_r;
  logic [3:0]        flush_cnt_r;
  logic [31:0]       new_pc_r;
  logic [CW-1:0]     stall_cnt_r;
  logic              stall_timeout_r;

  logic              exc_valid_s;
  logic [31:0]       exc_target_s;
  logic [NSTAGE-1:0] merge_s;
  logic              merge_acc_s;
  logic [NSTAGE-1:0] stall_s;
  logic              flush_s;
  logic              pc_load_s;
  logic [31:0]       new_pc_s;
  logic              busy_s;
  logic              stalling_s;
  logic              timeout_set_s;

  // Decode the MEM-stage exception code into a redirect target; unmapped codes are ignored.
  always_comb begin
    exc_valid_s  = 1'b0;
    exc_target_s = 32'h0000_0000;
    case (bus.excepttype_i)
      32'h0000_0001: begin
        exc_valid_s  = 1'b1;
        exc_target_s = INT_VEC;
      end
      32'h0000_0008, 32'h0000_000a, 32'h0000_000c, 32'h0000_000d: begin
        exc_valid_s  = 1'b1;
        exc_target_s = GEN_VEC;
      end
      32'h0000_000e: begin
        exc_valid_s  = 1'b1;
        exc_target_s = bus.cp0_epc_i;
      end
      default: begin
        exc_valid_s  = 1'b0;
        exc_target_s = 32'h0000_0000;
      end
    endcase
  end

  // Thermometer merge: a stalled stage also freezes every earlier stage down to the PC.
  always_comb begin
    merge_s     = '0;
    merge_acc_s = 1'b0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      merge_acc_s = merge_acc_s | bus.stallreq_i[k];
      merge_s[k]  = merge_acc_s;
    end
  end

  // Output decode: reset forces everything quiet, FLUSH replays the stored target.
  always_comb begin
    stall_s   = '0;
    flush_s   = 1'b0;
    pc_load_s = 1'b0;
    new_pc_s  = 32'h0000_0000;
    busy_s    = 1'b0;
    if (rst) begin
      stall_s   = '0;
      flush_s   = 1'b0;
    end else if (state_r == ST_FLUSH) begin
      flush_s   = 1'b1;
      busy_s    = 1'b1;
      new_pc_s  = new_pc_r;
    end else if (exc_valid_s) begin
      flush_s   = 1'b1;
      pc_load_s = 1'b1;
      new_pc_s  = exc_target_s;
    end else begin
      stall_s   = merge_s;
    end
  end

  // Flush state machine: captures the redirect target and counts out the flush window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= 4'd0;
      new_pc_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (exc_valid_s) begin
            new_pc_r <= exc_target_s;
            if (FLUSH_CYCLES > 1) begin
              state_r     <= ST_FLUSH;
              flush_cnt_r <= FLUSH_RELOAD;
            end else begin
              state_r     <= ST_IDLE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          flush_cnt_r <= flush_cnt_r - 4'd1;
          if (flush_cnt_r == 4'd1) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_FLUSH;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          flush_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  assign stalling_s    = |stall_s;
  assign timeout_set_s = stalling_s && (stall_cnt_r == CNT_ARM);

  // Stall watchdog: saturating run-length counter with a sticky flag; a new set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r     <= '0;
      stall_timeout_r <= 1'b0;
    end else begin
      if (!stalling_s) begin
        stall_cnt_r <= '0;
      end else if (stall_cnt_r != CNT_MAX) begin
        stall_cnt_r <= stall_cnt_r + CW'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (timeout_set_s) begin
        stall_timeout_r <= 1'b1;
      end else if (bus.timeout_clr_i) begin
        stall_timeout_r <= 1'b0;
      end else begin
        stall_timeout_r <= stall_timeout_r;
      end
    end
  end

  assign bus.stall_o         = stall_s;
  assign bus.flush_o         = flush_s;
  assign bus.pc_load_o       = pc_load_s;
  assign bus.new_pc_o        = new_pc_s;
  assign bus.busy_o          = busy_s;
  assign bus.stall_timeout_o = stall_timeout_r;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Self-checking bench for pipe_ctrl_gen (NSTAGE=6, FLUSH_CYCLES=3, STALL_TIMEOUT=4).
// Directed scenarios compare against literal expectations; the random scenario
// compares every output against a cycle-level behavioural model.
module tb_pipe_ctrl_gen;
  localparam int NS  = 6;
  localparam int FC  = 3;
  localparam int TMO = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  // model state
  int          m_left;
  logic [31:0] m_pc;
  int          m_run;
  logic        m_flag;
  // model expectations for the current cycle
  logic [NS-1:0] exp_stall;
  logic          exp_flush, exp_pcl, exp_busy, exp_tmo;
  logic [31:0]   exp_pc;
  logic          exp_valid;
  logic [31:0]   exp_tgt;

  pipe_ctrl_gen_if #(.NSTAGE(NS)) bus ();

  pipe_ctrl_gen #(
    .NSTAGE(NS), .FLUSH_CYCLES(FC), .INT_VEC(32'h0000_0020),
    .GEN_VEC(32'h0000_0040), .STALL_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_eval();
    int hi;
    int t;
    exp_valid = 1'b1;
    case (bus.excepttype_i)
      32'd1:                        exp_tgt = 32'h0000_0020;
      32'd8, 32'd10, 32'd12, 32'd13: exp_tgt = 32'h0000_0040;
      32'd14:                       exp_tgt = bus.cp0_epc_i;
      default: begin exp_valid = 1'b0; exp_tgt = 32'h0; end
    endcase
    hi = -1;
    for (int k = 0; k < NS; k++) if (bus.stallreq_i[k]) hi = k;
    t = (1 << (hi + 1)) - 1;
    exp_stall = '0; exp_flush = 1'b0; exp_pcl = 1'b0; exp_busy = 1'b0; exp_pc = 32'h0;
    exp_tmo = m_flag;
    if (rst) begin
      exp_stall = '0;
    end else if (m_left > 0) begin
      exp_flush = 1'b1; exp_busy = 1'b1; exp_pc = m_pc;
    end else if (exp_valid) begin
      exp_flush = 1'b1; exp_pcl = 1'b1; exp_pc = exp_tgt;
    end else begin
      exp_stall = t[NS-1:0];
    end
  endtask

  task automatic drive(input logic [NS-1:0] req, input logic [31:0] code,
                       input logic [31:0] epc, input logic clr, input logic r);
    rst = r;
    bus.stallreq_i = req;
    bus.excepttype_i = code;
    bus.cp0_epc_i = epc;
    bus.timeout_clr_i = clr;
    #4;
    model_eval();
  endtask

  task automatic tick();
    logic set;
    model_eval();
    @(posedge clk);
    if (rst) begin
      m_left = 0; m_pc = 32'h0; m_run = 0; m_flag = 1'b0;
    end else begin
      set = (exp_stall != '0) && (m_run == TMO - 1);
      if (exp_stall != '0) m_run++; else m_run = 0;
      if (set) m_flag = 1'b1; else if (bus.timeout_clr_i) m_flag = 1'b0;
      if (m_left > 0) m_left--;
      else if (exp_valid) begin m_pc = exp_tgt; m_left = FC - 1; end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(6'($urandom), 32'd8, $urandom, 1'b0, 1'b1);
      if (i > 0) begin
        n_chk++;
        if ({bus.stall_o, bus.flush_o, bus.pc_load_o, bus.new_pc_o, bus.busy_o, bus.stall_timeout_o} !== 42'h0) begin
          n_err++;
          $display("FAIL reset got stall=%b flush=%b pcl=%b pc=%h busy=%b tmo=%b want all 0",
                   bus.stall_o, bus.flush_o, bus.pc_load_o, bus.new_pc_o, bus.busy_o, bus.stall_timeout_o);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall_merge();
    logic [NS-1:0] reqs [4] = '{6'b001000, 6'b000100, 6'b001100, 6'b100001};
    logic [NS-1:0] want [4] = '{6'b001111, 6'b000111, 6'b001111, 6'b111111};
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < ((p == 0) ? 3 : 1); c++) begin
        drive(reqs[p], 32'd0, 32'h0, 1'b0, 1'b0);
        n_chk++;
        if (bus.stall_o !== want[p] || bus.flush_o !== 1'b0) begin
          n_err++;
          $display("FAIL stall_merge p%0d got stall=%b flush=%b want %b/0", p, bus.stall_o, bus.flush_o, want[p]);
        end
        tick();
      end
      drive(6'b000000, 32'd0, 32'h0, 1'b0, 1'b0);
      n_chk++;
      if (bus.stall_o !== 6'b000000) begin
        n_err++;
        $display("FAIL stall_release p%0d got %b want 000000", p, bus.stall_o);
      end
      tick();
    end
  endtask

  task automatic test_exc_beats_stall();
    drive(6'b000100, 32'h8, 32'h0, 1'b0, 1'b0);
    n_chk++;
    if (bus.stall_o !== 6'b0 || bus.flush_o !== 1'b1 || bus.pc_load_o !== 1'b1 || bus.new_pc_o !== 32'h40) begin
      n_err++;
      $display("FAIL exc_beats_stall got stall=%b flush=%b pcl=%b pc=%h want 000000/1/1/00000040",
               bus.stall_o, bus.flush_o, bus.pc_load_o, bus.new_pc_o);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(6'b000100, 32'h0, 32'h0, 1'b0, 1'b0);
      n_chk++;
      if (bus.stall_o !== 6'b0 || bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'h40 || bus.busy_o !== 1'b1) begin
        n_err++;
        $display("FAIL exc_flush_hold c%0d got stall=%b flush=%b pc=%h busy=%b", c, bus.stall_o, bus.flush_o, bus.new_pc_o, bus.busy_o);
      end
      tick();
    end
  endtask

  task automatic test_eret_flush();
    logic [31:0] codes [3] = '{32'he, 32'h1, 32'h0};
    for (int c = 0; c < 3; c++) begin
      drive(6'b0, codes[c], 32'h0000_1234, 1'b0, 1'b0);
      n_chk++;
      if (bus.flush_o !== 1'b1 || bus.pc_load_o !== (c == 0) || bus.new_pc_o !== 32'h1234 || bus.busy_o !== (c != 0)) begin
        n_err++;
        $display("FAIL eret_flush c%0d got flush=%b pcl=%b pc=%h busy=%b want 1/%0d/00001234/%0d",
                 c, bus.flush_o, bus.pc_load_o, bus.new_pc_o, bus.busy_o, c == 0, c != 0);
      end
      tick();
    end
    drive(6'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_chk++;
    if (bus.flush_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.new_pc_o !== 32'h0) begin
      n_err++;
      $display("FAIL eret_done got flush=%b busy=%b pc=%h want 0/0/0", bus.flush_o, bus.busy_o, bus.new_pc_o);
    end
    tick();
  endtask

  task automatic test_unmapped();
    drive(6'b000010, 32'h5, 32'h0, 1'b0, 1'b0);
    n_chk++;
    if (bus.flush_o !== 1'b0 || bus.pc_load_o !== 1'b0 || bus.stall_o !== 6'b000011) begin
      n_err++;
      $display("FAIL unmapped got flush=%b pcl=%b stall=%b want 0/0/000011", bus.flush_o, bus.pc_load_o, bus.stall_o);
    end
    tick();
    drive(6'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_watchdog();
    for (int c = 1; c <= 4; c++) begin
      drive(6'b000001, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      n_chk++;
      if (bus.stall_timeout_o !== (c == 4)) begin
        n_err++;
        $display("FAIL watchdog_run c%0d got %b want %0d", c, bus.stall_timeout_o, c == 4);
      end
    end
    drive(6'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    n_chk++;
    if (bus.stall_timeout_o !== 1'b1) begin
      n_err++;
      $display("FAIL watchdog_sticky got %b want 1", bus.stall_timeout_o);
    end
    drive(6'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    n_chk++;
    if (bus.stall_timeout_o !== 1'b0) begin
      n_err++;
      $display("FAIL watchdog_clear got %b want 0", bus.stall_timeout_o);
    end
  endtask

  task automatic test_reset_mid_flush();
    drive(6'b0, 32'hc, 32'h0, 1'b0, 1'b0);
    tick();
    drive(6'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    n_chk++;
    if (bus.flush_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.pc_load_o !== 1'b0 || bus.new_pc_o !== 32'h0) begin
      n_err++;
      $display("FAIL rst_in_flush got flush=%b busy=%b pcl=%b pc=%h want 0", bus.flush_o, bus.busy_o, bus.pc_load_o, bus.new_pc_o);
    end
    tick();
    drive(6'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_chk++;
    if ({bus.stall_o, bus.flush_o, bus.pc_load_o, bus.new_pc_o, bus.busy_o} !== 41'h0) begin
      n_err++;
      $display("FAIL rst_after_flush got flush=%b busy=%b pcl=%b pc=%h stall=%b want all 0",
               bus.flush_o, bus.busy_o, bus.pc_load_o, bus.new_pc_o, bus.stall_o);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] code_tab [12] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h5, 32'h0};
    logic [31:0] code;
    logic [NS-1:0] req;
    for (int i = 0; i < 400; i++) begin
      code = code_tab[$urandom_range(0, 11)];
      if ($urandom_range(0, 30) == 0) code = $urandom;
      req = ($urandom_range(0, 2) == 0) ? 6'b0 : 6'($urandom);
      drive(req, code, $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 40) == 0));
      n_chk++;
      if (bus.stall_o !== exp_stall || bus.flush_o !== exp_flush || bus.pc_load_o !== exp_pcl ||
          bus.new_pc_o !== exp_pc || bus.busy_o !== exp_busy || bus.stall_timeout_o !== exp_tmo) begin
        n_err++;
        $display("FAIL random i%0d got stall=%b flush=%b pcl=%b pc=%h busy=%b tmo=%b want %b/%b/%b/%h/%b/%b",
                 i, bus.stall_o, bus.flush_o, bus.pc_load_o, bus.new_pc_o, bus.busy_o, bus.stall_timeout_o,
                 exp_stall, exp_flush, exp_pcl, exp_pc, exp_busy, exp_tmo);
      end
      tick();
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    m_left = 0; m_pc = 32'h0; m_run = 0; m_flag = 1'b0;
    rst = 1'b1;
    bus.stallreq_i = '0; bus.excepttype_i = 32'h0; bus.cp0_epc_i = 32'h0; bus.timeout_clr_i = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_stall_merge();
    test_exc_beats_stall();
    test_eret_flush();
    test_unmapped();
    test_watchdog();
    test_reset_mid_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
